// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the byte-stream input and the instruction-memory write port of the
//   boot-time program loader.
//   Signals:
//     rx_valid   - byte available from the serial receiver
//     rx_data    - byte value
//     rx_ready   - loader accepts the byte (transfer on rx_valid && rx_ready)
//     imem_we    - one-cycle write strobe to instruction memory
//     imem_addr  - word address of the current write
//     imem_wdata - 32-bit instruction word being written
//   Modports:
//     master - the loader (consumes bytes, drives the memory write port)
//     slave  - the environment (byte source and instruction memory)
interface imem_loader_if #(
  parameter int ADDR_W = 14
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Reads a 4-byte little-endian length header L
//   from the byte stream, then assembles L little-endian 32-bit words and
//   writes them to instruction memory at word addresses 0..L-1. Every word's
//   opcode (bits 6:0) is checked against the decodable set; the first illegal
//   one is recorded in err/err_addr, but loading continues.
//   Ports:
//     clk      - clock, all state updates on the rising edge
//     rst      - synchronous active-high reset
//     start    - arm the loader (honoured in IDLE, DONE, ERR only)
//     bus      - imem_loader_if master: byte stream in, memory write port out
//     busy     - high while reading the header or the payload
//     done     - high once a load has completed
//     err      - sticky: illegal opcode seen or header length too large
//     err_addr - word address of the first illegal opcode (0 if none)
module imem_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Largest legal length is exactly the memory capacity.
  localparam logic [32:0]     CAP      = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] REM_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_n;
  logic [1:0]        cnt_r;        // byte position within header/word, wraps 3->0
  logic [23:0]       asm_r;        // lower three bytes of the word being assembled
  logic [ADDR_W:0]   remaining_r;  // words still to be accepted
  logic [ADDR_W-1:0] widx_r;       // index of the next word to be written
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [ADDR_W-1:0] err_addr_r;

  logic              rx_ready_s;
  logic              xfer_s;
  logic              last_byte_s;
  logic [31:0]       word_s;
  logic              len_over_s;

  // Decodable opcode set of the core.
  function automatic logic opcode_legal(input logic [6:0] op);
    logic ok;
    case (op)
      7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111,
      7'b0110011, 7'b1010011, 7'b1100011, 7'b0010011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0111000: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The current byte completes the header or word; it sits in the top byte.
  assign word_s      = {bus.rx_data, asm_r};
  assign last_byte_s = (cnt_r == 2'd3);
  assign xfer_s      = bus.rx_valid && rx_ready_s;
  assign len_over_s  = ({1'b0, word_s} > CAP);

  // Byte acceptance: open in LEN, and in DATA only while words remain so the
  // byte after the final one is never consumed.
  always_comb begin
    rx_ready_s = 1'b0;
    case (state_r)
      S_LEN:   rx_ready_s = 1'b1;
      S_DATA:  rx_ready_s = (remaining_r != REM_ZERO);
      default: rx_ready_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n = S_LEN;
        end else begin
          state_n = state_r;
        end
      end
      S_LEN: begin
        if (xfer_s && last_byte_s) begin
          if (word_s == 32'd0) begin
            state_n = S_DONE;
          end else if (len_over_s) begin
            state_n = S_ERR;
          end else begin
            state_n = S_DATA;
          end
        end else begin
          state_n = S_LEN;
        end
      end
      S_DATA: begin
        // remaining hits zero on the final byte; the following cycle carries
        // the last write strobe, after which the load is complete.
        if (remaining_r == REM_ZERO) begin
          state_n = S_DONE;
        end else begin
          state_n = S_DATA;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: header/word assembly, memory write port, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= 2'd0;
      asm_r       <= 24'd0;
      remaining_r <= REM_ZERO;
      widx_r      <= IDX_ZERO;
      we_r        <= 1'b0;
      addr_r      <= IDX_ZERO;
      wdata_r     <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_addr_r  <= IDX_ZERO;
    end else begin
      we_r   <= 1'b0;
      busy_r <= (state_n == S_LEN) || (state_n == S_DATA);
      done_r <= (state_n == S_DONE);
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            cnt_r      <= 2'd0;
            widx_r     <= IDX_ZERO;
            addr_r     <= IDX_ZERO;
            err_r      <= 1'b0;
            err_addr_r <= IDX_ZERO;
          end
        end
        S_LEN: begin
          if (xfer_s) begin
            cnt_r <= cnt_r + 2'd1;
            asm_r <= {bus.rx_data, asm_r[23:8]};
            if (last_byte_s) begin
              remaining_r <= word_s[ADDR_W:0];
              if (word_s != 32'd0 && len_over_s) begin
                err_r <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer_s) begin
            cnt_r <= cnt_r + 2'd1;
            asm_r <= {bus.rx_data, asm_r[23:8]};
            if (last_byte_s) begin
              // Write lands one cycle after the accepting edge and overlaps
              // acceptance of the next word's first byte.
              we_r        <= 1'b1;
              wdata_r     <= word_s;
              addr_r      <= widx_r;
              widx_r      <= widx_r + IDX_ONE;
              remaining_r <= remaining_r - REM_ONE;
              if (!opcode_legal(word_s[6:0]) && !err_r) begin
                err_r      <= 1'b1;
                err_addr_r <= widx_r;
              end
            end
          end
        end
        default: begin
          we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_s;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign err_addr       = err_addr_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader (ADDR_W=4, 16-word memory). A model holds
//   the program being sent and derives the expected write sequence and the
//   expected first illegal opcode; a compare process matches every write
//   strobe against it, and end-of-load state is checked after each load.
module tb_imem_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          write_cnt = 0;
  logic [31:0] last_wdata = 32'd0;
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] prog[$];
  logic [6:0]  legal_ops [12] = '{7'h03, 7'h23, 7'h07, 7'h27, 7'h33, 7'h53,
                                  7'h63, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h38};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Index of the first word whose opcode is outside the legal set, or -1.
  function automatic int first_illegal();
    for (int i = 0; i < prog.size(); i++) begin
      bit ok = 1'b0;
      for (int j = 0; j < 12; j++) if (prog[i][6:0] == legal_ops[j]) ok = 1'b1;
      if (!ok) return i;
    end
    return -1;
  endfunction

  // Compare process: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      write_cnt++;
      last_wdata = bus.imem_wdata;
      if (exp_data_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        check("write_addr", 32'(bus.imem_addr), 32'(exp_addr_q.pop_front()));
        check("write_data", bus.imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n = 0;
    logic rdy;
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    do begin
      rdy = bus.rx_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    bus.rx_valid = 1'b0;
    if (!rdy) begin
      total_cnt++;
      $display("FAIL send_byte: rx_ready stayed 0 for byte %h expected 1", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_err"}, {27'd0, err, err_addr}, 32'd0);
  endtask

  // Full load of prog: header, payload with optional random gaps, optional
  // start pulse before data byte number start_at; then end-state checks.
  task automatic run_load(input int gapmax, input int start_at);
    int n   = prog.size();
    int bad = first_illegal();
    int cyc = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(i);
      exp_data_q.push_back(prog[i]);
    end
    pulse_start();
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", {27'd0, err, err_addr}, 32'd0);
    for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), 0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k == start_at) begin
          pulse_start();
          @(negedge clk);
          check("ignored_start_busy", 32'(busy), 32'd1);
        end
        send_byte(8'(prog[i] >> (8 * k)), (gapmax == 0) ? 0 : $urandom_range(0, gapmax));
      end
    end
    @(negedge clk);
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("load_done", 32'(done), 32'd1);
    check("writes_outstanding", 32'(exp_data_q.size()), 32'd0);
    check("end_err", 32'(err), (bad >= 0) ? 32'd1 : 32'd0);
    check("end_err_addr", 32'(err_addr), (bad >= 0) ? 32'(bad) : 32'd0);
    check("end_idle_port", {29'd0, bus.rx_ready, busy, bus.imem_we}, 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int wc0;
    rst          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Four legal words from address 0.
    prog = '{32'h00000513, 32'h00100093, 32'h002081B3, 32'h0000006F};
    wc0 = write_cnt;
    run_load(0, -1);
    check("t1_write_count", 32'(write_cnt - wc0), 32'd4);
    check("t1_last_word", last_wdata, 32'h0000006F);

    // Zero-length header: done the cycle after the 4th byte, no writes.
    wc0 = write_cnt;
    pulse_start();
    @(negedge clk);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_writes", 32'(write_cnt - wc0), 32'd0);

    // Two illegal words: only the first is recorded.
    prog = '{32'h00000513, 32'hFFFFFFFF, 32'h0000007F};
    wc0 = write_cnt;
    run_load(0, -1);
    check("t3_err_addr_lit", 32'(err_addr), 32'd1);
    check("t3_write_count", 32'(write_cnt - wc0), 32'd3);

    // Restart from DONE with err set.
    prog = '{32'h00100093};
    run_load(0, -1);
    check("restart_word", last_wdata, 32'h00100093);

    // L=17 overflows a 16-word memory.
    wc0 = write_cnt;
    pulse_start();
    @(negedge clk);
    send_byte(8'h11, 0);
    for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
    @(negedge clk);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_done_busy", {30'd0, done, busy}, 32'd0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("ovf_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("ovf_err_hold", 32'(err), 32'd1);
    check("ovf_writes", 32'(write_cnt - wc0), 32'd0);

    // L=16 fills memory exactly.
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(32'h00000013 | (32'(i) << 20));
    wc0 = write_cnt;
    run_load(0, -1);
    check("fill_write_count", 32'(write_cnt - wc0), 32'd16);

    // Random rx_valid gaps and a start pulse mid-payload.
    prog = '{32'h00000513, 32'h00100093, 32'h002081B3, 32'h0000006F};
    run_load(3, 9);

    // Reset in the middle of a word.
    wc0 = write_cnt;
    pulse_start();
    @(negedge clk);
    send_byte(8'h02, 0);
    for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    check("midrst_writes", 32'(write_cnt - wc0), 32'd0);
    rst = 1'b0;

    // Counters must be clear: a fresh one-word load lands at address 0.
    prog = '{32'h0000006F};
    run_load(0, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader; produces the instruction words that the fetch/decode path later consumes.
- Accepts an 8-bit byte stream (valid/ready) from the serial receiver and reads a 4-byte length header.
- Assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory from address 0.
- Checks every word's opcode field against the set the core decodes and flags the first illegal one.

Parameters:
ADDR_W, 14, instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  arm loader; honoured in IDLE, DONE, ERR only
rx_valid  input  1  byte available from serial receiver
rx_data  input  8  byte value
rx_ready  output  1  loader accepts byte; transfer when rx_valid&&rx_ready
imem_we  output  1  one-cycle write strobe to instruction memory
imem_addr  output  ADDR_W  word address of current write
imem_wdata  output  32  instruction word being written
busy  output  1  high in LEN and DATA states
done  output  1  high in DONE state (load completed)
err  output  1  sticky: illegal opcode seen, or length overflow
err_addr  output  ADDR_W  word address of first illegal opcode; 0 if none

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, err_addr=0; byte counter and length cleared. Reset mid-load aborts immediately; memory writes already issued are not undone.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE: rx_ready=0. start -> LEN; clears err, err_addr, word address, byte counter.
- LEN: rx_ready=1. Accepts 4 bytes, little-endian (first byte = bits 7:0), into a 32-bit length L.
  - On the 4th byte: L==0 -> DONE.
  - L > 2^ADDR_W -> ERR with err=1.
  - Otherwise -> DATA.
- DATA: rx_ready=1 every cycle. Bytes are assembled little-endian into a shift/assembly register, with a 2-bit byte counter that wraps 3->0.
  - The cycle after the 4th byte handshake: imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = current word index. The index increments after the write.
  - Write latency: 1 cycle after the accepting edge. Back-to-back bytes at full rate are sustained; the write of word k overlaps acceptance of word k+1's first byte.
- Opcode check on each completed word (bits 6:0).
  - Legal set: 0000011, 0100011, 0000111, 0100111, 0110011, 1010011, 1100011, 0010011, 1101111, 1100111, 0110111, 0111000.
  - Illegal opcode while err==0: err=1 and err_addr=word index, both updated with the write strobe.
  - Later illegal words do not change err_addr. Illegal words are still written and loading continues.
- Completion: after the write strobe of word L-1, next state is DONE. rx_ready drops in the same cycle the final byte is accepted (combinational on the counter), so no extra byte is consumed.
- DONE: rx_ready=0, done=1. err and err_addr hold. start -> LEN (restart; clears done, err, err_addr, counters).
- ERR: rx_ready=0, done=0, err=1. Only start or rst leave the state.
- start while busy: ignored.
- rx_valid while rx_ready=0: ignored; the byte is not consumed.
- imem_addr never exceeds 2^ADDR_W-1, guaranteed by the length check. L == 2^ADDR_W is legal and fills memory exactly.
- Gaps in rx_valid: no timeout; the loader waits indefinitely in LEN or DATA.

Test Plan:
- Reset, then start; send 04 00 00 00 followed by bytes for 0x00000513, 0x00100093, 0x002081B3, 0x0000006F -> exactly four imem_we pulses at addresses 0..3 with those words; done=1, err=0; rx_ready=0 afterward.
- Header 00 00 00 00 -> DONE one cycle after the 4th byte; no imem_we pulse; done=1.
- Load 3 words with word 1 = 0xFFFFFFFF and word 2 = 0x0000007F -> all 3 written; err=1, err_addr=1 (not 2); done=1.
- ADDR_W=4, header 11 00 00 00 (L=17) -> ERR, err=1, no writes; header 10 00 00 00 (L=16) -> 16 writes at addresses 0..15, done=1.
- rx_valid toggled randomly, plus a start pulse mid-DATA -> word contents and addresses identical to the gap-free case; start ignored; assert rst mid-word -> all outputs return to reset values the next cycle.
- From DONE with err=1, assert start and load 1 legal word -> err cleared, err_addr=0, write at address 0, done=1.
